sys_mem_responder: RTL and testbench
====================================

Name: sys_mem_responder

Overview:
- Bus-side responder (main memory model/controller) for the system bus driven by the data cache controller.
- Serves 16-word line fills (read bursts) with one SysAck per word followed by SysReady, and write-through single-word writes.
- Sits between the cache's Sys* port and an on-chip word array; the array is synthesizable, and reset does not clear it.

Parameters:
- AW, 12, word-address width of the memory array (2**AW 32-bit words).
- WAIT_STATES, 2, idle cycles between request acceptance and the first data/ack cycle.
- BEAT_GAP, 0, idle cycles inserted between consecutive burst beats.
- LINE_WORDS, 16, words per cache line (fixed 4-bit word offset, address bits [5:2]).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- SysStrobe  in  1  request valid; sampled only in IDLE.
- SysRW  in  1  1 = read (line fill), 0 = write (single word).
- SysAddress  in  32  byte address; [1:0] ignored.
- SysData_in  in  32  write data from the cache.
- SysData_out  out  32  read data to the cache; valid in the cycle SysAck=1.
- SysAck  out  1  one-cycle pulse per transferred word.
- SysReady  out  1  one-cycle pulse marking transaction completion.

Behaviour:
- Reset (async): state=IDLE; SysAck=0, SysReady=0, SysData_out=0; beat counter and wait counter=0; array contents retained.
- IDLE: on SysStrobe=1, latch SysRW, SysAddress[AW+1:2], and SysData_in; load wait counter with WAIT_STATES; go to WAIT. If WAIT_STATES=0, go directly to BURST (read) or WRITE (write).
- WAIT: decrement the counter each cycle; at 0, go to BURST if latched RW=1, otherwise go to WRITE. Inputs are ignored here.
- BURST: beat k (0..15) reads array word {line_base, k[3:0]}, where line_base = latched word address with [3:0] cleared.
  - Beats always start at k=0 regardless of the request's word offset, because the cache's counter is flushed to 0.
  - SysData_out is registered and updates in the same cycle SysAck=1.
  - After each beat except the last, insert BEAT_GAP cycles with SysAck=0; SysData_out holds its last value.
  - After beat 15, go to DONE.
- WRITE: in one cycle, array[latched word addr] <= latched data, and SysAck=1 for that cycle; go to DONE.
- DONE: SysReady=1 for exactly one cycle with SysAck=0; go to IDLE. SysStrobe is not sampled in DONE, so a strobe still high here is not re-accepted.
- Back-to-back: a strobe in the IDLE cycle immediately after DONE is accepted, giving a minimum 1-cycle IDLE gap.
- Read latency: first SysAck arrives WAIT_STATES+1 cycles after the accepting edge.
- Total read transaction: WAIT_STATES + 16 + 15*BEAT_GAP + 1 (DONE) cycles after acceptance.
- Address wrap: word address bits above AW are ignored (modulo 2**AW); a line never crosses its 64-byte boundary.
- SysStrobe/SysRW/SysAddress/SysData_in changes after acceptance have no effect, because all fields are latched.
- Reset mid-burst or mid-write: return immediately to IDLE with outputs at 0. A write not yet in WRITE state is dropped; a write already performed stays.
- Array read/write conflict: impossible, since there is one transaction at a time.

Decomposition:
- Shared defines header (with the cache):
  - RW_READ=1'b1, RW_WRITE=1'b0.
  - WAITSTATE=2'd2, used as the WAIT_STATES default.
  - OFS=4 line word-offset width.
  - Line size in words (16).
  - State encodings IDLE/WAIT/BURST/WRITE/DONE.
- One sub-module, sys_mem_array: 2**AW x 32 synchronous-write, registered-read single-port RAM with ports clock, addr, we, wdata, rdata.
- The FSM, counters and latches live in sys_mem_responder.

Test Plan:
- Reset then idle: hold reset 3 cycles, release with SysStrobe=0 -> SysAck=SysReady=0 and SysData_out=0 for 20 cycles.
- Line fill: preload words 0x40..0x4F with 0xA000_0000+k; strobe RW=1, addr 0x0000_0108 -> first ack 3 cycles after acceptance; 16 consecutive acks with data 0xA000_0000..0xA000_000F in order; SysReady 1 cycle after last ack; 0 extra acks.
- Write then read back: strobe RW=0, addr 0x0000_0124, data 0xDEAD_BEEF -> single ack, then SysReady next cycle; subsequent fill of line 0x100 returns 0xDEAD_BEEF on beat 9, other words unchanged.
- BEAT_GAP=1, WAIT_STATES=0 build: fill -> acks on alternate cycles, first ack 1 cycle after acceptance, transaction length 32 cycles; strobe held high throughout DONE is not re-accepted; a strobe reasserted in IDLE starts a second fill.
- Reset mid-burst: assert reset after beat 5 -> outputs 0 asynchronously; after release a new fill restarts at beat 0 with correct data.
- Address wrap (AW=12): write 0x1234_5678 to addr 0x0000_4004 -> reading line at 0x0000_0000 returns it on beat 1.

Source files
------------

// File: rtl/sys_mem_responder_pkg.sv
// Shared system-bus definitions used by the data cache and the memory responder.
// Holds the bus direction codes, default wait states, line geometry and FSM encoding.
package sys_mem_responder_pkg;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [1:0] WAITSTATE = 2'd2;

    localparam int OFS       = 4;
    localparam int LINE_SIZE = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_BURST = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/sys_mem_responder_array.sv
// Single-port word RAM behind the responder: synchronous write, registered read.
// Contents are deliberately not reset so memory survives a bus reset.
module sys_mem_array #(
    parameter int AW = 12
) (
    input  logic          clock,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sys_mem_responder.sv
// System-bus memory responder: 16-word line fills with per-word ack, and single-word writes.
// Request fields are latched on acceptance; the word array is the sys_mem_array instance.
//
// state    | meaning
// IDLE     | waiting for SysStrobe, latches request on acceptance
// WAIT     | counting WAIT_STATES idle cycles
// BURST    | issuing line beats 0..15 (plus one drain cycle for the last ack)
// WRITE    | single-word array write, SysAck high
// DONE     | SysReady pulse, strobe not sampled
module sys_mem_responder
    import sys_mem_responder_pkg::*;
#(
    parameter int AW          = 12,
    parameter int WAIT_STATES = int'(WAITSTATE),
    parameter int BEAT_GAP    = 0,
    parameter int LINE_WORDS  = LINE_SIZE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        SysStrobe,
    input  logic        SysRW,
    input  logic [31:0] SysAddress,
    input  logic [31:0] SysData_in,
    output logic [31:0] SysData_out,
    output logic        SysAck,
    output logic        SysReady
);

    localparam logic [7:0] WS8       = 8'(WAIT_STATES);
    localparam logic [7:0] GAP8      = 8'(BEAT_GAP);
    localparam logic [4:0] LAST_BEAT = 5'(LINE_WORDS - 1);
    localparam logic [4:0] DRAIN     = 5'(LINE_WORDS);

    state_t        state;
    state_t        state_nx;
    logic          rw_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   data_q;
    logic [7:0]    wait_cnt;
    logic [7:0]    gap_cnt;
    logic [4:0]    beat;
    logic          rd_ack_q;
    logic [31:0]   hold_q;
    logic          issue;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   rdata;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{SysAddress[31:AW+2], SysAddress[1:0]};

    sys_mem_array #(
        .AW (AW)
    ) u_array (
        .clock (clock),
        .addr  (mem_addr),
        .we    (mem_we),
        .wdata (data_q),
        .rdata (rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (SysStrobe) begin
                    if (WS8 == 8'd0) begin
                        state_nx = (SysRW == RW_READ) ? ST_BURST : ST_WRITE;
                    end else begin
                        state_nx = ST_WAIT;
                    end
                end
            end
            // Leaving on count 1 keeps WAIT exactly WAIT_STATES cycles long.
            ST_WAIT: begin
                if (wait_cnt <= 8'd1) begin
                    state_nx = (rw_q == RW_READ) ? ST_BURST : ST_WRITE;
                end
            end
            ST_BURST: begin
                if (beat == DRAIN) begin
                    state_nx = ST_DONE;
                end
            end
            ST_WRITE: state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // A beat's address is issued one cycle ahead of its ack to cover the registered RAM read.
    always_comb begin
        issue       = (state == ST_BURST) && (beat != DRAIN) && (gap_cnt == 8'd0);
        SysAck      = rd_ack_q || (state == ST_WRITE);
        SysReady    = (state == ST_DONE);
        mem_we      = (state == ST_WRITE);
        mem_addr    = (state == ST_BURST) ? {addr_q[AW-1:OFS], beat[OFS-1:0]} : addr_q;
        SysData_out = rd_ack_q ? rdata : hold_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rw_q     <= RW_WRITE;
            addr_q   <= '0;
            data_q   <= '0;
            wait_cnt <= '0;
            gap_cnt  <= '0;
            beat     <= '0;
            rd_ack_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            rd_ack_q <= issue;
            if (rd_ack_q) begin
                hold_q <= rdata;
            end
            case (state)
                ST_IDLE: begin
                    if (SysStrobe) begin
                        rw_q     <= SysRW;
                        addr_q   <= SysAddress[AW+1:2];
                        data_q   <= SysData_in;
                        wait_cnt <= WS8;
                        beat     <= '0;
                        gap_cnt  <= '0;
                    end
                end
                ST_WAIT: wait_cnt <= wait_cnt - 8'd1;
                ST_BURST: begin
                    if (issue) begin
                        beat    <= beat + 5'd1;
                        gap_cnt <= (beat == LAST_BEAT) ? 8'd0 : GAP8;
                    end else if (gap_cnt != 8'd0) begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_mem_responder.sv
// Directed bench for sys_mem_responder: default build (a) and a WAIT_STATES=0, BEAT_GAP=1 build (b).
module tb_sys_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        strobe_a, rw_a, ack_a, rdy_a;
    logic [31:0] addr_a, din_a, dout_a;
    logic        strobe_b, rw_b, ack_b, rdy_b;
    logic [31:0] addr_b, din_b, dout_b;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] got [16];
    int          first_ack, last_ack, ready_idx, acks;

    always #5 clock = ~clock;

    sys_mem_responder dut_a (
        .clock       (clock),
        .reset       (reset),
        .SysStrobe   (strobe_a),
        .SysRW       (rw_a),
        .SysAddress  (addr_a),
        .SysData_in  (din_a),
        .SysData_out (dout_a),
        .SysAck      (ack_a),
        .SysReady    (rdy_a)
    );

    sys_mem_responder #(
        .WAIT_STATES (0),
        .BEAT_GAP    (1)
    ) dut_b (
        .clock       (clock),
        .reset       (reset),
        .SysStrobe   (strobe_b),
        .SysRW       (rw_b),
        .SysAddress  (addr_b),
        .SysData_in  (din_b),
        .SysData_out (dout_b),
        .SysAck      (ack_b),
        .SysReady    (rdy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic stb, input logic rw,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            strobe_b = stb; rw_b = rw; addr_b = a; din_b = d;
        end else begin
            strobe_a = stb; rw_a = rw; addr_a = a; din_a = d;
        end
    endtask

    // Index i counts negedges after the accepting edge (i=0 is the first cycle after it).
    task automatic bus_txn(input bit sel, input logic rw, input logic [31:0] addr,
                           input logic [31:0] data, input int abort_at, input bit linger);
        logic        a, r;
        logic [31:0] d;
        first_ack = -1; last_ack = -1; ready_idx = -1; acks = 0;
        for (int k = 0; k < 16; k++) got[k] = 32'h0;
        @(negedge clock);
        drive(sel, 1'b1, rw, addr, data);
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (i == 0) drive(sel, 1'b0, ~rw, addr ^ 32'h0000_0FC0, ~data);
            a = sel ? ack_b : ack_a;
            r = sel ? rdy_b : rdy_a;
            d = sel ? dout_b : dout_a;
            if (a === 1'b1) begin
                if (acks < 16) got[acks] = d;
                if (first_ack < 0) first_ack = i;
                last_ack = i;
                acks++;
            end
            if (r === 1'b1 && ready_idx < 0) ready_idx = i;
            if (linger && acks == 16 && ready_idx < 0) drive(sel, 1'b1, 1'b1, addr, data);
            if (linger && ready_idx == i) drive(sel, 1'b0, 1'b1, addr, data);
            if (abort_at > 0 && acks == abort_at) begin
                reset = 1'b1;
                #1;
                check("abort ack", 32'(ack_a), 32'd0);
                check("abort ready", 32'(rdy_a), 32'd0);
                check("abort data", dout_a, 32'h0);
                @(negedge clock);
                @(negedge clock);
                reset = 1'b0;
                return;
            end
            if (ready_idx >= 0 && i == ready_idx + 3) break;
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            check("idle ack", 32'(ack_a), 32'd0);
            check("idle ready", 32'(rdy_a), 32'd0);
            check("idle data", dout_a, 32'h0);
        end
        check("idle ack b", 32'(ack_b), 32'd0);
        check("idle ready b", 32'(rdy_b), 32'd0);
        check("idle data b", dout_b, 32'h0);

        for (int k = 0; k < 16; k++) begin
            bus_txn(1'b0, 1'b0, 32'h100 + 32'(4 * k), 32'hA000_0000 + 32'(k), 0, 1'b0);
            if (k == 0) begin
                check("write acks", 32'(acks), 32'd1);
                check("write ack cycle", 32'(first_ack), 32'd2);
                check("write ready cycle", 32'(ready_idx), 32'd3);
            end
        end

        bus_txn(1'b0, 1'b1, 32'h0000_0108, 32'h0, 0, 1'b0);
        check("fill1 first ack", 32'(first_ack), 32'd3);
        check("fill1 last ack", 32'(last_ack), 32'd18);
        check("fill1 ready", 32'(ready_idx), 32'd19);
        check("fill1 acks", 32'(acks), 32'd16);
        for (int k = 0; k < 16; k++)
            check($sformatf("fill1 beat%0d", k), got[k], 32'hA000_0000 + 32'(k));

        bus_txn(1'b0, 1'b0, 32'h0000_0124, 32'hDEAD_BEEF, 0, 1'b0);
        check("wr2 acks", 32'(acks), 32'd1);
        check("wr2 ready", 32'(ready_idx), 32'd3);

        bus_txn(1'b0, 1'b1, 32'h0000_0100, 32'h0, 0, 1'b0);
        check("fill2 acks", 32'(acks), 32'd16);
        for (int k = 0; k < 16; k++)
            check($sformatf("fill2 beat%0d", k), got[k],
                  (k == 9) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(k));

        bus_txn(1'b0, 1'b1, 32'h0000_0100, 32'h0, 6, 1'b0);
        check("abort beats seen", got[5], 32'hA000_0005);

        bus_txn(1'b0, 1'b1, 32'h0000_0100, 32'h0, 0, 1'b0);
        check("fill3 first ack", 32'(first_ack), 32'd3);
        check("fill3 acks", 32'(acks), 32'd16);
        for (int k = 0; k < 16; k++)
            check($sformatf("fill3 beat%0d", k), got[k],
                  (k == 9) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(k));

        bus_txn(1'b0, 1'b0, 32'h0000_4004, 32'h1234_5678, 0, 1'b0);
        bus_txn(1'b0, 1'b1, 32'h0000_0000, 32'h0, 0, 1'b0);
        check("wrap beat1", got[1], 32'h1234_5678);
        check("wrap acks", 32'(acks), 32'd16);

        for (int k = 0; k < 16; k++) begin
            bus_txn(1'b1, 1'b0, 32'h200 + 32'(4 * k), 32'hB000_0000 + 32'(k), 0, 1'b0);
            if (k == 0) begin
                check("b write ack cycle", 32'(first_ack), 32'd0);
                check("b write ready", 32'(ready_idx), 32'd1);
            end
        end

        bus_txn(1'b1, 1'b1, 32'h0000_023C, 32'h0, 0, 1'b1);
        check("b fill first ack", 32'(first_ack), 32'd1);
        check("b fill last ack", 32'(last_ack), 32'd31);
        check("b fill ready", 32'(ready_idx), 32'd32);
        check("b fill acks", 32'(acks), 32'd16);
        check("b fill beat0", got[0], 32'hB000_0000);
        check("b fill beat1", got[1], 32'hB000_0001);
        check("b fill beat15", got[15], 32'hB000_000F);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("b no reaccept", 32'(ack_b), 32'd0);
        end

        bus_txn(1'b1, 1'b1, 32'h0000_0200, 32'h0, 0, 1'b0);
        check("b fill2 first ack", 32'(first_ack), 32'd1);
        check("b fill2 acks", 32'(acks), 32'd16);
        for (int k = 0; k < 16; k++)
            check($sformatf("b fill2 beat%0d", k), got[k], 32'hB000_0000 + 32'(k));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
